// File: rtl/vram_text_reader.sv
// Character-cell text reader: walks the VGA raster, fetches code/attribute words from VRAM port B
// and presents them with a fixed 3-cycle latency alongside the delayed sync signals.
module vram_text_reader #(
    parameter int unsigned TEXT_COLS = 64,
    parameter int unsigned TEXT_ROWS = 32,
    parameter int unsigned CELL_H    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic        hs,
    input  logic        vs,
    input  logic        line_start,
    input  logic        frame_start,
    input  logic [4:0]  scroll_row,
    input  logic        cursor_en,
    input  logic [4:0]  cursor_row,
    input  logic [5:0]  cursor_col,
    output logic [10:0] vram_adb,
    output logic        vram_ceb,
    input  logic [8:0]  vram_doutb,
    output logic [7:0]  char_code,
    output logic [3:0]  glyph_line,
    output logic [2:0]  glyph_col,
    output logic        inverse,
    output logic        text_de,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic [10:0] PxLimit  = 11'(TEXT_COLS * 8);
    localparam logic [6:0]  RowLimit = 7'(TEXT_ROWS);
    localparam logic [3:0]  ScanLast = 4'(CELL_H - 1);
    localparam logic [5:0]  RowSat   = 6'd32;
    localparam logic [9:0]  PxSat    = 10'h3ff;

    // Raster position state
    logic [9:0] px_q, px_d;
    logic [3:0] scan_q, scan_d;
    logic [5:0] row_q, row_d;
    logic [4:0] scroll_q, scroll_d;
    logic [5:0] blink_cnt_q, blink_cnt_d;
    logic       frame_seen_q, frame_seen_d;
    logic       line_de_q, line_de_d;

    // Pipeline side-band
    logic       s1_win, s1_hs, s1_vs, s1_cur;
    logic [2:0] s1_gcol;
    logic [3:0] s1_gline;
    logic       s2_win, s2_hs, s2_vs, s2_cur;
    logic [2:0] s2_gcol;
    logic [3:0] s2_gline;

    logic       in_win;
    logic [5:0] col;
    logic [4:0] vram_row;
    logic       blink;
    logic       cur_hit;

    always_comb begin
        px_d         = px_q;
        scan_d       = scan_q;
        row_d        = row_q;
        scroll_d     = scroll_q;
        blink_cnt_d  = blink_cnt_q;
        frame_seen_d = frame_seen_q;
        line_de_d    = line_de_q;

        if (frame_start) begin
            // Frame start wins over a coincident line start: clear, never step.
            scan_d       = 4'd0;
            row_d        = 6'd0;
            scroll_d     = scroll_row;
            blink_cnt_d  = blink_cnt_q + 6'd1;
            frame_seen_d = 1'b1;
            line_de_d    = 1'b0;
            if (line_start) begin
                px_d = 10'd0;
            end
        end else if (line_start) begin
            px_d      = 10'd0;
            line_de_d = 1'b0;
            // Blank lines (no de) do not advance the glyph scanline.
            if (line_de_q) begin
                if (scan_q == ScanLast) begin
                    scan_d = 4'd0;
                    if (row_q != RowSat) begin
                        row_d = row_q + 6'd1;
                    end
                end else begin
                    scan_d = scan_q + 4'd1;
                end
            end
        end else if (de) begin
            line_de_d = 1'b1;
            if (px_q != PxSat) begin
                px_d = px_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q         <= 10'd0;
            scan_q       <= 4'd0;
            row_q        <= 6'd0;
            scroll_q     <= 5'd0;
            blink_cnt_q  <= 6'd0;
            frame_seen_q <= 1'b0;
            line_de_q    <= 1'b0;
        end else begin
            px_q         <= px_d;
            scan_q       <= scan_d;
            row_q        <= row_d;
            scroll_q     <= scroll_d;
            blink_cnt_q  <= blink_cnt_d;
            frame_seen_q <= frame_seen_d;
            line_de_q    <= line_de_d;
        end
    end

    always_comb begin
        col      = px_q[8:3];
        vram_row = row_q[4:0] + scroll_q;
        blink    = blink_cnt_q[5];
        in_win   = de & frame_seen_q & ({1'b0, px_q} < PxLimit) & ({1'b0, row_q} < RowLimit);
        // Compared in VRAM coordinates so the cursor scrolls with the text.
        cur_hit  = cursor_en & blink & (vram_row == cursor_row) & (col == cursor_col) & in_win;
    end

    // Stage 1: address issue plus side-band capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_adb <= 11'd0;
            vram_ceb <= 1'b0;
            s1_win   <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_cur   <= 1'b0;
            s1_gcol  <= 3'd0;
            s1_gline <= 4'd0;
        end else begin
            if (in_win) begin
                vram_adb <= {vram_row, col};
            end
            vram_ceb <= in_win;
            s1_win   <= in_win;
            s1_hs    <= hs & frame_seen_q;
            s1_vs    <= vs & frame_seen_q;
            s1_cur   <= cur_hit;
            s1_gcol  <= frame_seen_q ? px_q[2:0] : 3'd0;
            s1_gline <= frame_seen_q ? scan_q : 4'd0;
        end
    end

    // Stage 2: side-band waits while the RAM produces data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_win   <= 1'b0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_cur   <= 1'b0;
            s2_gcol  <= 3'd0;
            s2_gline <= 4'd0;
        end else begin
            s2_win   <= s1_win;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_cur   <= s1_cur;
            s2_gcol  <= s1_gcol;
            s2_gline <= s1_gline;
        end
    end

    // Stage 3: registered outputs, RAM data qualified by the window bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code  <= 8'd0;
            glyph_line <= 4'd0;
            glyph_col  <= 3'd0;
            inverse    <= 1'b0;
            text_de    <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
        end else begin
            char_code  <= s2_win ? vram_doutb[7:0] : 8'd0;
            inverse    <= s2_win & (vram_doutb[8] ^ s2_cur);
            text_de    <= s2_win;
            glyph_line <= s2_gline;
            glyph_col  <= s2_gcol;
            hs_out     <= s2_hs;
            vs_out     <= s2_vs;
        end
    end

endmodule
